// File: rtl/outputs_collector.sv
// outputs_collector: gathers single result bits written by address into one
// packed WIDTH-bit word. Per-bit valid flags are tracked against a mask latched
// on start; once every masked bit is valid the word is offered on a
// valid/ready handshake.
// Optional feature: define OUT_TIMEOUT_EN to add a collect-phase cycle counter
// that forces an incomplete word out after TIMEOUT_CYCLES cycles and raises
// timeout. Without it, COLLECT waits indefinitely and timeout is tied to 0.
module outputs_collector #(
   parameter int WIDTH          = 32,
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  expect_mask,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              val,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  valid_bits,
   output logic              busy,
   output logic              err,
   output logic              timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] valid_q;
   logic [WIDTH-1:0] mask_q;
   logic             err_q;

   logic [WIDTH-1:0] sel;
   logic             hit;
   logic             complete;
   logic             restart;
   logic             timeout_hit;

   // Start is honoured everywhere except PRESENT, where a pending word must not be lost.
   assign restart = start && (state != PRESENT);

   // Address decode: addresses at or beyond WIDTH shift out to an all-zero select,
   // so they can never alias onto low bits and always miss the mask.
   always_comb begin
      sel      = WIDTH'(1) << wr_addr;
      hit      = |(sel & mask_q);
      complete = ((valid_q & mask_q) == mask_q);
   end

`ifdef OUT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout     = timeout_q;

   // Collect-phase cycle counter; completion takes priority over an expiring count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else if (restart) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else if (state == COLLECT) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (!complete && timeout_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   // Control FSM plus the data/flag registers it owns.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         data_q  <= '0;
         valid_q <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
      end else if (restart) begin
         // A write in the same cycle as start is dropped silently.
         state   <= COLLECT;
         mask_q  <= expect_mask;
         data_q  <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en) begin
                  err_q <= 1'b1;
               end
            end
            COLLECT: begin
               if (wr_en) begin
                  if (hit) begin
                     data_q  <= val ? (data_q | sel) : (data_q & ~sel);
                     valid_q <= valid_q | sel;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               // Completion looks at the registered flags, so the word appears
               // one edge after the write that finished it.
               if (complete || timeout_hit) begin
                  state <= PRESENT;
               end
            end
            PRESENT: begin
               if (wr_en) begin
                  err_q <= 1'b1;
               end
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_data   = data_q & mask_q;
   assign out_valid  = (state == PRESENT);
   assign busy       = (state != IDLE);
   assign err        = err_q;
   assign valid_bits = valid_q;

endmodule

// File: tb/tb_outputs_collector.sv
// Self-checking bench for outputs_collector: directed scenarios plus randomized
// transactions, all checked through a scoreboard popped by a handshake monitor.
module tb_outputs_collector;

`ifdef OUT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 64;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] expect_mask;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic        val;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] valid_bits;
   logic        busy;
   logic        err;
   logic        timeout;

   outputs_collector #(
      .WIDTH(32),
      .ADDR_W(5),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .expect_mask(expect_mask),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .val(val),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .valid_bits(valid_bits),
      .busy(busy),
      .err(err),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        to;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests    = 0;
   int   n_fail     = 0;
   int   words_seen = 0;

   // Reference model: which mask bits have been accepted, and their values.
   logic [31:0] m_mask;
   bit          m_wr  [32];
   bit          m_val [32];
   bit          m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic t);
      exp_t e;
      e.data = d;
      e.to   = t;
      sb_q.push_back(e);
   endtask

   task automatic model_start(input logic [31:0] mk);
      m_mask = mk;
      m_err  = 1'b0;
      for (int i = 0; i < 32; i++) begin
         m_wr[i]  = 1'b0;
         m_val[i] = 1'b0;
      end
   endtask

   // Write as seen while collecting: accepted only for in-mask addresses.
   task automatic model_write(input int a, input bit v);
      if (a < 32 && m_mask[a]) begin
         m_wr[a]  = 1'b1;
         m_val[a] = v;
      end else begin
         m_err = 1'b1;
      end
   endtask

   function automatic logic [31:0] model_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         if (m_mask[i] && m_wr[i] && m_val[i]) w[i] = 1'b1;
      end
      return w;
   endfunction

   function automatic logic [31:0] model_flags();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w[i] = m_wr[i];
      return w;
   endfunction

   function automatic bit model_done();
      bit d;
      d = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (m_mask[i] && !m_wr[i]) d = 1'b0;
      end
      return d;
   endfunction

   task automatic do_start(input logic [31:0] mk);
      start       = 1'b1;
      expect_mask = mk;
      tick();
      start = 1'b0;
   endtask

   task automatic do_write(input int a, input bit v);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      val     = v;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_word(input string name, input int budget);
      int base;
      int k;
      base = words_seen;
      k    = 0;
      while (words_seen == base && k < budget) begin
         tick();
         k++;
      end
      chk(name, 32'(words_seen != base), 32'd1);
   endtask

   // Monitor: every accepted word is matched against the oldest expectation.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", out_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("word_data", out_data, mon_e.data);
            chk("word_timeout", 32'(timeout), 32'(mon_e.to));
         end
         words_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int bad;
      logic [31:0] mk;
      int a;
      int s;
      int n_e;
      int n_r;
      int r;
      bit v;

      reset = 1'b0; start = 1'b0; expect_mask = '0; wr_en = 1'b0;
      wr_addr = '0; val = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_valid_bits", valid_bits, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_timeout", timeout, 0);
      reset = 1'b1;
      tick();

      // Full word, ready held high
      out_ready = 1'b1;
      do_start(32'hFFFF_FFFF);
      model_start(32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         do_write(i, bit'(i % 2));
         model_write(i, bit'(i % 2));
      end
      chk("t1_latency_early", out_valid, 0);
      push_exp(32'hAAAA_AAAA, 1'b0);
      base = words_seen;
      tick();
      chk("t1_latency", out_valid, 1);
      tick();
      chk("t1_handshake", 32'(words_seen - base), 1);
      chk("t1_valid_low", out_valid, 0);
      chk("t1_busy", busy, 0);
      chk("t1_err", err, 0);

      // Partial mask with backpressure
      out_ready = 1'b0;
      do_start(32'h0001_0004);
      model_start(32'h0001_0004);
      do_write(16, 1'b1);
      do_write(2, 1'b0);
      push_exp(32'h0001_0000, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_data", out_data, 32'h0001_0000);
         tick();
      end
      base = words_seen;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_handshake", 32'(words_seen - base), 1);
      chk("t2_valid_fall", out_valid, 0);
      chk("t2_data_kept", out_data, 32'h0001_0000);

      // Address / mask errors
      do_start(32'h0000_00FF);
      model_start(32'h0000_00FF);
      do_write(8, 1'b1);
      model_write(8, 1'b1);
      do_write(31, 1'b1);
      model_write(31, 1'b1);
      chk("t3_err_set", err, 1);
      chk("t3_no_flags", valid_bits, 0);
      for (int i = 0; i < 8; i++) begin
         v = bit'($urandom_range(0, 1));
         do_write(i, v);
         model_write(i, v);
      end
      push_exp(model_word(), 1'b0);
      out_ready = 1'b1;
      wait_word("t3_word", 6);
      out_ready = 1'b0;
      chk("t3_err_sticky", err, 32'(m_err));
      do_start(32'h0000_0003);
      model_start(32'h0000_0003);
      chk("t3_err_cleared", err, 0);
      do_write(0, 1'b1);
      model_write(0, 1'b1);
      do_write(1, 1'b0);
      model_write(1, 1'b0);
      push_exp(model_word(), 1'b0);
      out_ready = 1'b1;
      wait_word("t3b_word", 6);
      out_ready = 1'b0;
      do_write(5, 1'b1);
      chk("idle_wr_err", err, 1);
      chk("idle_wr_flags", valid_bits, 32'h3);
      chk("idle_wr_data", out_data, 32'h1);

      // Overwrite: last write wins
      do_start(32'h0000_000F);
      model_start(32'h0000_000F);
      do_write(3, 1'b1); model_write(3, 1'b1);
      do_write(3, 1'b0); model_write(3, 1'b0);
      do_write(0, 1'b1); model_write(0, 1'b1);
      do_write(1, 1'b1); model_write(1, 1'b1);
      do_write(2, 1'b0); model_write(2, 1'b0);
      chk("t4_no_err", err, 0);
      push_exp(model_word(), 1'b0);
      out_ready = 1'b1;
      wait_word("t4_word", 6);
      out_ready = 1'b0;

      // Start colliding with a write, from IDLE then from COLLECT
      start = 1'b1; expect_mask = 32'h1; wr_en = 1'b1; wr_addr = 5'd0; val = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b0;
      model_start(32'h1);
      chk("coll_idle_flags", valid_bits, 0);
      chk("coll_idle_err", err, 0);
      chk("coll_idle_busy", busy, 1);
      start = 1'b1; expect_mask = 32'h2; wr_en = 1'b1; wr_addr = 5'd1; val = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b0;
      model_start(32'h2);
      chk("coll_col_flags", valid_bits, 0);
      chk("coll_col_err", err, 0);
      do_write(1, 1'b1);
      model_write(1, 1'b1);
      push_exp(model_word(), 1'b0);
      out_ready = 1'b1;
      wait_word("coll_word", 6);
      out_ready = 1'b0;

      // Writes and start while a word is pending
      do_start(32'h1);
      model_start(32'h1);
      do_write(0, 1'b1);
      model_write(0, 1'b1);
      push_exp(model_word(), 1'b0);
      tick();
      chk("pres_valid", out_valid, 1);
      do_write(0, 1'b0);
      m_err = 1'b1;
      chk("pres_wr_err", err, 32'(m_err));
      chk("pres_wr_data", out_data, 32'h1);
      do_start(32'hF);
      chk("pres_start_busy", busy, 1);
      chk("pres_start_valid", out_valid, 1);
      chk("pres_start_data", out_data, 32'h1);
      out_ready = 1'b1;
      wait_word("pres_word", 6);
      out_ready = 1'b0;
      tick();
      chk("pres_start_dropped", busy, 0);
      chk("pres_flags_kept", valid_bits, 32'h1);

      // Empty mask completes after one collect cycle
      out_ready = 1'b1;
      do_start(32'h0);
      model_start(32'h0);
      chk("zero_collect", out_valid, 0);
      chk("zero_busy", busy, 1);
      push_exp(32'h0, 1'b0);
      wait_word("zero_word", 6);
      out_ready = 1'b0;

      // Asynchronous reset in the middle of collection
      do_start(32'hFFFF_FFFF);
      model_start(32'hFFFF_FFFF);
      for (int i = 0; i < 10; i++) do_write(i, 1'b1);
      chk("arst_pre_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err, 0);
      chk("arst_flags", valid_bits, 0);
      chk("arst_data", out_data, 0);
      chk("arst_timeout", timeout, 0);
      #1;
      reset = 1'b1;
      tick();
      chk("arst_idle_busy", busy, 0);
      chk("arst_idle_valid", out_valid, 0);

      // Collect-phase timeout
      do_start(32'hF);
      model_start(32'hF);
      do_write(0, 1'b1);
      model_write(0, 1'b1);
      if (TO_EN) begin
         push_exp(model_word(), 1'b1);
         repeat (TO - 2) tick();
         chk("to_early", out_valid, 0);
         tick();
         chk("to_valid", out_valid, 1);
         chk("to_flag", timeout, 1);
         chk("to_data", out_data, 32'h1);
         out_ready = 1'b1;
         wait_word("to_word", 6);
         out_ready = 1'b0;
         chk("to_flag_kept", timeout, 1);
         do_start(32'h0);
         chk("to_flag_cleared", timeout, 0);
      end else begin
         bad = 0;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b1 || timeout !== 1'b0 || out_valid !== 1'b0) bad++;
         end
         chk("noto_waits", bad, 0);
         do_start(32'h0);
      end
      model_start(32'h0);
      push_exp(32'h0, 1'b0);
      out_ready = 1'b1;
      wait_word("to_restart_word", 6);
      out_ready = 1'b0;

      // Randomized transactions
      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 4))
            0: mk = 32'hFFFF_FFFF;
            1: mk = $urandom;
            2: mk = $urandom & $urandom & $urandom;
            3: mk = 32'h1 << $urandom_range(0, 31);
            default: mk = (t % 3 == 0) ? 32'h0 : $urandom;
         endcase
         out_ready = 1'b0;
         do_start(mk);
         model_start(mk);
         n_e = 0;
         n_r = 0;
         while (!model_done()) begin
            r = $urandom_range(0, 7);
            s = $urandom_range(0, 31);
            a = -1;
            if (r == 0 && n_e < 3 && mk != 32'hFFFF_FFFF) begin
               for (int j = 0; j < 32; j++)
                  if (a < 0 && !mk[(s + j) % 32]) a = (s + j) % 32;
               n_e++;
            end else if (r == 1 && n_r < 3 && model_flags() != 0) begin
               for (int j = 0; j < 32; j++)
                  if (a < 0 && m_wr[(s + j) % 32]) a = (s + j) % 32;
               n_r++;
            end else begin
               for (int j = 0; j < 32; j++)
                  if (a < 0 && mk[(s + j) % 32] && !m_wr[(s + j) % 32]) a = (s + j) % 32;
            end
            v = bit'($urandom_range(0, 1));
            do_write(a, v);
            model_write(a, v);
         end
         push_exp(model_word(), 1'b0);
         repeat ($urandom_range(0, 3)) tick();
         out_ready = 1'b1;
         wait_word("rnd_word", 10);
         out_ready = 1'b0;
         chk("rnd_err", err, 32'(m_err));
         chk("rnd_flags", valid_bits, model_flags());
      end

      repeat (3) tick();
      chk("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/outputs_collector.md
Name: outputs_collector

Overview:
- Write-side counterpart to the input bit-register block. Compute elements write single result bits by address; the block tracks per-bit valid flags against an expected mask.
- When every expected bit is valid, it presents one packed WIDTH-bit result word over a valid/ready handshake to the host/readback logic.
- One instance per output port of the runtime fabric.

Parameters:
- WIDTH, 32, number of result bits in the output word.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= WIDTH.
- TIMEOUT_CYCLES, 1024, collect-phase timeout limit; used only when OUT_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear valid flags and data, latch expect_mask, enter COLLECT.
- expect_mask  input  WIDTH  bits required to complete a word; sampled only on accepted start.
- wr_en  input  1  bit-write strobe.
- wr_addr  input  ADDR_W  bit index written.
- val  input  1  bit value written.
- out_data  output  WIDTH  packed result word (data & mask).
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts word.
- valid_bits  output  WIDTH  current per-bit valid flags.
- busy  output  1  high in COLLECT or PRESENT.
- err  output  1  sticky write-error flag; cleared by reset or accepted start.
- timeout  output  1  word was presented incomplete; cleared on accepted start.

Behaviour:
- Reset (reset=0, async): state IDLE; data, valid flags, mask, counter cleared. out_data=0, out_valid=0, valid_bits=0, busy=0, err=0, timeout=0.
- States: IDLE, COLLECT, PRESENT.
- IDLE:
  - start -> COLLECT; latch mask; clear data and valid flags, err, timeout.
  - wr_en in IDLE is ignored and sets err.
- COLLECT:
  - wr_en with wr_addr < WIDTH and mask[wr_addr]=1: data[wr_addr]<=val, valid[wr_addr]<=1. Rewriting an already-valid bit overwrites it (last write wins), no error.
  - wr_en with wr_addr >= WIDTH or mask[wr_addr]=0: no state change, err<=1.
  - Completion check uses the registered flags: when (valid & mask)==mask -> PRESENT. Latency: write completing the mask at edge N, state PRESENT and out_valid=1 after edge N+1.
  - start in COLLECT restarts: flags, data, err and timeout cleared; new mask latched; stays COLLECT.
  - start and wr_en in the same cycle: start wins; the write is dropped with no err.
  - expect_mask=0 on start: COLLECT for one cycle, then PRESENT with out_data=0.
- PRESENT:
  - out_valid=1; out_data=data & mask, held stable until handshake.
  - out_valid & out_ready at an edge -> IDLE; out_valid falls next cycle; out_data keeps its last value.
  - out_ready is ignored when out_valid=0.
  - wr_en in PRESENT is ignored and sets err; data does not change.
  - start in PRESENT is ignored (no drop of a pending word).
- busy = (state != IDLE). valid_bits reflects the flags register directly.
- Width rule: wr_addr compares at ADDR_W bits; no wrap-around onto low bits.

Optional Feature:
- Macro OUT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to COLLECT (including restart) and increments every COLLECT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the next edge enters PRESENT with partial data (invalid bits read 0) and timeout<=1.
  - If completion and timeout coincide, completion wins and timeout stays 0.
- Not defined: no counter is synthesized, timeout is tied to 0, and COLLECT waits indefinitely.

Test Plan:
- Full word: start with mask=32'hFFFF_FFFF; write val=addr[0] to addresses 0..31; out_ready=1 -> out_valid one cycle after the last write, out_data=32'hAAAA_AAAA, then IDLE, busy=0, err=0.
- Partial mask with backpressure: mask=32'h0001_0004; write addr16=1, addr2=0; hold out_ready=0 for 5 cycles -> out_data=32'h0001_0000 stable, out_valid held; raise out_ready -> out_valid=0 next cycle.
- Errors: mask=32'h0000_00FF; write addr 8 and addr 31 -> err=1, valid_bits=0; write addr 0..7 -> completes normally, err remains 1; a new start clears err.
- Overwrite and collision: write addr3=1 then addr3=0 -> out_data bit3=0; start together with wr_en -> write dropped, valid_bits=0, err=0.
- Async reset mid-COLLECT after 10 writes: drive reset=0 between edges -> all outputs 0 immediately; after release, state IDLE.
- OUT_TIMEOUT_EN, TIMEOUT_CYCLES=16: mask=32'hF, write only addr0=1 -> PRESENT after 16 COLLECT cycles with out_data=32'h1 and timeout=1. Without the macro, busy stays 1 and timeout stays 0 for 100 cycles.
